// File: rtl/mem_pkg.sv
// Shared definitions for the banked data memory: default geometry matching
// the ISA memory map, the clear-engine state type and address wrap helper.
package mem_pkg;

    localparam int MEM_DW        = 8;
    localparam int MEM_AW        = 8;
    localparam int MEM_LANES     = 2;
    localparam int MEM_WR_OFFSET = 30;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } mem_state_e;

    // Sum of two addresses reduced modulo 2**aw; callers truncate to AW bits.
    function automatic logic [63:0] wrap_addr(input logic [63:0] base,
                                              input logic [63:0] inc,
                                              input int unsigned aw);
        logic [63:0] mask;
        mask = (64'd1 << aw) - 64'd1;
        return (base + inc) & mask;
    endfunction

endpackage

// File: rtl/mem_clear_engine.sv
// Sequential clear engine: walks every word of the memory writing zero
// after reset, and holds Busy until the last word has been cleared.
module mem_clear_engine
    import mem_pkg::*;
#(
    parameter int AW             = MEM_AW,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    output logic          busy_o,
    output logic          clrWe_o,
    output logic [AW-1:0] clrAddr_o
);

    localparam logic [0:0] ST_CLEAR = 1'(CLEAR);
    localparam logic [0:0] ST_IDLE  = 1'(IDLE);

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    // One word per cycle; the final word hands over to IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_CLEAR) begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == {AW{1'b1}}) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy_o    = (state_q == ST_CLEAR);
    assign clrWe_o   = busy_o && !reset_i;
    assign clrAddr_o = ptr_q;

endmodule

// File: rtl/data_mem_banked.sv
// Multi-lane data memory: one address pointer, LANES consecutive words per
// read, masked writes at a fixed offset, and a sequential clear after reset.
module data_mem_banked
    import mem_pkg::*;
#(
    parameter int DW             = MEM_DW,
    parameter int AW             = MEM_AW,
    parameter int LANES          = MEM_LANES,
    parameter int WR_OFFSET      = MEM_WR_OFFSET,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [AW-1:0]       DataAddress,
    input  logic                ReadMem,
    input  logic                WriteMem,
    input  logic [LANES-1:0]    WrMask,
    input  logic [LANES*DW-1:0] DataIn,
    output logic [LANES*DW-1:0] DataOut,
    output logic                RdValid,
    output logic                Busy,
    output logic                AccessErr
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]       mem [DEPTH];
    logic                clrWe;
    logic [AW-1:0]       clrAddr;
    logic                rdAccept;
    logic                wrAccept;
    logic [AW-1:0]       rdAddr [LANES];
    logic [AW-1:0]       wrAddr [LANES];
    logic [LANES*DW-1:0] rdData;
    logic                accessErr_q;

    mem_clear_engine #(
        .AW             (AW),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk_i     (CLK),
        .reset_i   (reset),
        .busy_o    (Busy),
        .clrWe_o   (clrWe),
        .clrAddr_o (clrAddr)
    );

    assign rdAccept = ReadMem  && !Busy && !reset;
    assign wrAccept = WriteMem && !Busy && !reset;

    // Lane addresses wrap in AW bits; reads see the array before this edge's writes.
    always_comb begin
        rdData = '0;
        for (int i = 0; i < LANES; i++) begin
            rdAddr[i] = AW'(wrap_addr(64'(DataAddress), 64'(i), AW));
            wrAddr[i] = AW'(wrap_addr(64'(DataAddress), 64'(WR_OFFSET + i), AW));
            rdData[i*DW +: DW] = mem[rdAddr[i]];
        end
    end

    always_ff @(posedge CLK) begin
        if (clrWe) begin
            mem[clrAddr] <= '0;
        end else if (wrAccept) begin
            for (int i = 0; i < LANES; i++) begin
                if (WrMask[i]) begin
                    mem[wrAddr[i]] <= DataIn[i*DW +: DW];
                end
            end
        end
    end

    // Error pulse is aligned with the cycle a read would have returned data.
    always_ff @(posedge CLK) begin
        if (reset) begin
            accessErr_q <= 1'b0;
        end else begin
            accessErr_q <= Busy && (ReadMem || WriteMem);
        end
    end

    assign AccessErr = accessErr_q;

    generate
        if (READ_LATENCY == 0) begin : gen_comb_read
            assign DataOut = rdAccept ? rdData : '0;
            assign RdValid = rdAccept;
        end else begin : gen_reg_read
            logic [LANES*DW-1:0] dataOut_q;
            logic                rdValid_q;

            always_ff @(posedge CLK) begin
                if (reset) begin
                    dataOut_q <= '0;
                    rdValid_q <= 1'b0;
                end else begin
                    rdValid_q <= rdAccept;
                    if (rdAccept) begin
                        dataOut_q <= rdData;
                    end
                end
            end

            assign DataOut = dataOut_q;
            assign RdValid = rdValid_q;
        end
    endgenerate

endmodule
